serial_to_parallel_buffered: RTL and testbench

SERIAL_TO_PARALLEL_BUFFERED -- requirements
Module: serial_to_parallel_buffered

---
 rtl/serial_to_parallel_buffered_if.sv | 37 +++
 rtl/serial_to_parallel_buffered.sv | 89 ++++++++
 tb/tb_serial_to_parallel_buffered.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/serial_to_parallel_buffered_if.sv
// Bundle of serial input, parallel FIFO output and status signals for serial_to_parallel_buffered.
// master = producer/consumer environment, slave = the converter itself.
interface serial_to_parallel_buffered_if #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 4
);
    logic                     serial_valid;
    logic                     serial_data;
    logic                     parallel_valid;
    logic [width-1:0]         parallel_data;
    logic                     parallel_ready;
    logic                     busy;
    logic [$clog2(depth):0]   fill;
    logic                     overflow;

    modport master (
        output serial_valid,
        output serial_data,
        output parallel_ready,
        input  parallel_valid,
        input  parallel_data,
        input  busy,
        input  fill,
        input  overflow
    );

    modport slave (
        input  serial_valid,
        input  serial_data,
        input  parallel_ready,
        output parallel_valid,
        output parallel_data,
        output busy,
        output fill,
        output overflow
    );
endinterface

// File: rtl/serial_to_parallel_buffered.sv
// Assembles LSB-first serial bits into width-bit words and queues them in a depth-entry FIFO.
// Words completing into a full FIFO with no simultaneous pop are dropped and flagged.
module serial_to_parallel_buffered #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    serial_to_parallel_buffered_if.slave  bus
);
    localparam int unsigned CW = $clog2(width);
    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned FW = AW + 1;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [width-1:0] shift_q, shift_d;
    logic [width-1:0] word;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             overflow_q, overflow_d;
    logic [width-1:0] mem_q [depth];

    logic last_bit;
    logic full;
    logic empty;
    logic pop;
    logic wr_en;

    // Right shift: the first bit received ends up in bit 0 after width shifts.
    always_comb begin
        word     = {bus.serial_data, shift_q[width-1:1]};
        last_bit = bus.serial_valid && (cnt_q == CW'(width - 1));
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        if (bus.serial_valid) begin
            shift_d = word;
            cnt_d   = last_bit ? '0 : cnt_q + 1'b1;
        end
    end

    // A push into a full FIFO is still accepted when the head pops on the same edge.
    always_comb begin
        empty      = (fill_q == '0);
        full       = (fill_q == FW'(depth));
        pop        = !empty && bus.parallel_ready;
        wr_en      = last_bit && (!full || pop);
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
        fill_d     = fill_q;
        case ({wr_en, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
        overflow_d = overflow_q | (last_bit && full && !pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the output is gated by fill, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

    assign bus.parallel_valid = !empty;
    assign bus.parallel_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.busy           = (cnt_q != '0);
    assign bus.fill           = fill_q;
    assign bus.overflow       = overflow_q;
endmodule

// File: tb/tb_serial_to_parallel_buffered.sv
// Directed self-checking bench for serial_to_parallel_buffered with width=8, depth=4.
module tb_serial_to_parallel_buffered;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned checks = 0;
    int unsigned failures = 0;

    serial_to_parallel_buffered_if #(.width(8), .depth(4)) bus ();

    serial_to_parallel_buffered #(.width(8), .depth(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.serial_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int k = 0; k < 8; k++) begin
            bus.serial_valid = 1'b1;
            bus.serial_data  = w[k];
            tick();
        end
        bus.serial_valid = 1'b0;
    endtask

    initial begin
        logic [7:0]  w;
        logic [15:0] pair;
        int unsigned busy_cnt;
        int unsigned seen;
        int unsigned cyc0, cyc1;
        logic [7:0]  d0, d1;

        bus.serial_valid   = 1'b0;
        bus.serial_data    = 1'b0;
        bus.parallel_ready = 1'b0;
        do_reset();
        check_eq("rst_busy",  32'(bus.busy), 0);
        check_eq("rst_valid", 32'(bus.parallel_valid), 0);
        check_eq("rst_data",  32'(bus.parallel_data), 0);
        check_eq("rst_fill",  32'(bus.fill), 0);
        check_eq("rst_ovf",   32'(bus.overflow), 0);

        // 0xA5 on 8 consecutive cycles
        bus.parallel_ready = 1'b1;
        w = 8'hA5;
        busy_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            check_eq("a5_valid_early", 32'(bus.parallel_valid), 0);
            bus.serial_valid = 1'b1;
            bus.serial_data  = w[k];
            tick();
            if (bus.busy) busy_cnt++;
        end
        bus.serial_valid = 1'b0;
        check_eq("a5_busy_cycles", busy_cnt, 7);
        check_eq("a5_valid", 32'(bus.parallel_valid), 1);
        check_eq("a5_data",  32'(bus.parallel_data), 32'hA5);
        tick();
        check_eq("a5_valid_one_cycle", 32'(bus.parallel_valid), 0);

        // 0x3C with 1-3 cycle gaps between bits
        w = 8'h3C;
        for (int k = 0; k < 8; k++) begin
            bus.serial_valid = 1'b1;
            bus.serial_data  = w[k];
            tick();
            bus.serial_valid = 1'b0;
            if (k < 7) begin
                for (int g = 0; g <= (k % 3); g++) begin
                    tick();
                    check_eq("gap_busy",  32'(bus.busy), 1);
                    check_eq("gap_valid", 32'(bus.parallel_valid), 0);
                end
            end
        end
        check_eq("3c_valid", 32'(bus.parallel_valid), 1);
        check_eq("3c_data",  32'(bus.parallel_data), 32'h3C);
        check_eq("3c_busy",  32'(bus.busy), 0);
        tick();
        check_eq("3c_popped", 32'(bus.fill), 0);

        // ready=0, five back-to-back words
        bus.parallel_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_word(8'(i));
        check_eq("ovf_fill4", 32'(bus.fill), 4);
        check_eq("ovf_not_yet", 32'(bus.overflow), 0);
        send_word(8'h05);
        check_eq("ovf_fill_held", 32'(bus.fill), 4);
        check_eq("ovf_set", 32'(bus.overflow), 1);
        bus.parallel_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check_eq("ovf_drain_data", 32'(bus.parallel_data), 32'(i));
            check_eq("ovf_drain_fill", 32'(bus.fill), 32'(5 - i));
            tick();
        end
        check_eq("ovf_drain_empty", 32'(bus.fill), 0);
        check_eq("ovf_drain_valid", 32'(bus.parallel_valid), 0);
        check_eq("ovf_sticky", 32'(bus.overflow), 1);

        // full FIFO, pop on the edge 0x77 completes
        do_reset();
        check_eq("full_rst_ovf", 32'(bus.overflow), 0);
        bus.parallel_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(8'(8'h10 + i));
        check_eq("full_fill", 32'(bus.fill), 4);
        w = 8'h77;
        for (int k = 0; k < 8; k++) begin
            bus.serial_valid = 1'b1;
            bus.serial_data  = w[k];
            if (k == 7) bus.parallel_ready = 1'b1;
            tick();
        end
        bus.serial_valid = 1'b0;
        check_eq("full_simul_fill", 32'(bus.fill), 4);
        check_eq("full_simul_ovf",  32'(bus.overflow), 0);
        for (int i = 0; i < 4; i++) begin
            check_eq("full_drain_data", 32'(bus.parallel_data), (i == 3) ? 32'h77 : 32'(8'h11 + i));
            tick();
        end
        check_eq("full_drain_empty", 32'(bus.fill), 0);

        // reset mid-word with stored words
        bus.parallel_ready = 1'b0;
        send_word(8'h11);
        send_word(8'h22);
        w = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            bus.serial_valid = 1'b1;
            bus.serial_data  = w[k];
            tick();
        end
        check_eq("mid_busy_pre", 32'(bus.busy), 1);
        check_eq("mid_fill_pre", 32'(bus.fill), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.serial_valid = 1'b0;
        check_eq("mid_busy",  32'(bus.busy), 0);
        check_eq("mid_fill",  32'(bus.fill), 0);
        check_eq("mid_valid", 32'(bus.parallel_valid), 0);
        send_word(8'h81);
        check_eq("mid_81_valid", 32'(bus.parallel_valid), 1);
        check_eq("mid_81_data",  32'(bus.parallel_data), 32'h81);
        check_eq("mid_81_fill",  32'(bus.fill), 1);
        bus.parallel_ready = 1'b1;
        tick();
        check_eq("mid_81_popped", 32'(bus.fill), 0);

        // 0xC3 then 0x5A back-to-back, outputs 8 cycles apart
        pair = 16'h5AC3;
        seen = 0;
        cyc0 = 0;
        cyc1 = 0;
        d0 = '0;
        d1 = '0;
        for (int j = 1; j <= 20; j++) begin
            bus.serial_valid = (j <= 16);
            bus.serial_data  = (j <= 16) ? pair[j-1] : 1'b0;
            tick();
            if (bus.parallel_valid) begin
                if (seen == 0) begin cyc0 = j; d0 = bus.parallel_data; end
                else if (seen == 1) begin cyc1 = j; d1 = bus.parallel_data; end
                seen++;
            end
        end
        check_eq("b2b_count", seen, 2);
        check_eq("b2b_first", 32'(d0), 32'hC3);
        check_eq("b2b_second", 32'(d1), 32'h5A);
        check_eq("b2b_first_cycle", cyc0, 8);
        check_eq("b2b_spacing", cyc1 - cyc0, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
